// File: rtl/bram_banked_pipe_if.sv
// rtl/bram_banked_pipe_if.sv - per-bank write/read/clear bus for the banked NTT block RAM
interface bram_banked_pipe_if #(
    parameter int DSIZE = 32,
    parameter int DEPTH = 10,
    parameter int NBANK = 4
);
    logic [NBANK-1:0]       wen;
    logic [NBANK*DEPTH-1:0] waddr;
    logic [NBANK*DSIZE-1:0] din;
    logic [NBANK-1:0]       ren;
    logic [NBANK*DEPTH-1:0] raddr;
    logic [NBANK*DSIZE-1:0] dout;
    logic [NBANK-1:0]       dvalid;
    logic                   clr_start;
    logic                   busy;

    modport master (
        output wen, waddr, din, ren, raddr, clr_start,
        input  dout, dvalid, busy
    );

    modport slave (
        input  wen, waddr, din, ren, raddr, clr_start,
        output dout, dvalid, busy
    );
endinterface

// File: rtl/bram_banked_pipe.sv
// rtl/bram_banked_pipe.sv - NBANK independent 1W1R block RAMs with RLAT read pipeline and clear engine
module bram_banked_pipe #(
    parameter int DSIZE  = 32,
    parameter int DEPTH  = 10,
    parameter int MSIZE  = 1024,
    parameter int NBANK  = 4,
    parameter int RLAT   = 1,
    parameter int WFIRST = 0
) (
    input  logic clk,
    input  logic rst_n,
    bram_banked_pipe_if.slave bus
);
    // Counter is one bit wider than an address so MSIZE = 2^DEPTH compares without wrap.
    localparam logic [DEPTH:0] MSZ  = (DEPTH+1)'(MSIZE);
    localparam logic [DEPTH:0] LAST = (DEPTH+1)'(MSIZE - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state, state_nx;
    logic [DEPTH:0]   cnt;
    logic             idle;
    logic             clearing;
    logic [NBANK*DSIZE-1:0] dout_w;
    logic [NBANK-1:0]       dvalid_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.clr_start) state_nx = CLEAR;
            CLEAR:   if (cnt == LAST)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        idle     = (state == IDLE);
        clearing = (state == CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clearing) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign bus.busy   = clearing;
    assign bus.dout   = dout_w;
    assign bus.dvalid = dvalid_w;

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [DSIZE-1:0] mem [0:MSIZE-1];
        logic [DEPTH-1:0] wa, ra, mem_wa;
        logic [DSIZE-1:0] wd, mem_wd;
        logic             we_ext, mem_we, re, r_in, fwd;
        logic [DSIZE-1:0] pd [1:RLAT];
        logic [RLAT:1]    pv;

        assign wa     = bus.waddr[b*DEPTH +: DEPTH];
        assign ra     = bus.raddr[b*DEPTH +: DEPTH];
        assign wd     = bus.din[b*DSIZE +: DSIZE];
        // Out-of-range writes are dropped so a non-power-of-two bank never aliases.
        assign we_ext = idle && bus.wen[b] && ({1'b0, wa} < MSZ);
        assign mem_we = we_ext || clearing;
        assign mem_wa = clearing ? cnt[DEPTH-1:0] : wa;
        assign mem_wd = clearing ? '0 : wd;
        assign re     = idle && bus.ren[b];
        assign r_in   = ({1'b0, ra} < MSZ);
        assign fwd    = (WFIRST != 0) && we_ext && (wa == ra);

        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem[mem_wa] <= mem_wd;
            end
        end

        // Stage 1 is the RAM output register; later stages advance only on valid so dout holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pv <= '0;
                for (int k = 1; k <= RLAT; k++) begin
                    pd[k] <= '0;
                end
            end else begin
                pv[1] <= re;
                if (re) begin
                    pd[1] <= !r_in ? '0 : (fwd ? wd : mem[ra]);
                end
                for (int k = 2; k <= RLAT; k++) begin
                    pv[k] <= pv[k-1];
                    if (pv[k-1]) begin
                        pd[k] <= pd[k-1];
                    end
                end
            end
        end

        assign dout_w[b*DSIZE +: DSIZE] = pd[RLAT];
        assign dvalid_w[b]              = pv[RLAT];
    end
endmodule

// File: tb/tb_bram_banked_pipe.sv
// tb/tb_bram_banked_pipe.sv - directed bench for bram_banked_pipe (A: MSIZE 12 RLAT 1 read-first, B: MSIZE 16 RLAT 3 write-first)
module tb_bram_banked_pipe;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   nvec = 0;
    int   nmis = 0;

    always #5 clk = ~clk;

    bram_banked_pipe_if #(.DSIZE(32), .DEPTH(4), .NBANK(4)) ia ();
    bram_banked_pipe_if #(.DSIZE(32), .DEPTH(4), .NBANK(4)) ib ();

    bram_banked_pipe #(.DSIZE(32), .DEPTH(4), .MSIZE(12), .NBANK(4), .RLAT(1), .WFIRST(0))
        dut_a (.clk(clk), .rst_n(rst_a), .bus(ia));
    bram_banked_pipe #(.DSIZE(32), .DEPTH(4), .MSIZE(16), .NBANK(4), .RLAT(3), .WFIRST(1))
        dut_b (.clk(clk), .rst_n(rst_b), .bus(ib));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input logic [3:0] mask, input logic [3:0] addr, input logic [31:0] data);
        if (sel) begin ib.wen = mask; ib.waddr = {4{addr}}; ib.din = {4{data}}; end
        else     begin ia.wen = mask; ia.waddr = {4{addr}}; ia.din = {4{data}}; end
        cyc();
        if (sel) ib.wen = '0; else ia.wen = '0;
    endtask

    task automatic rd(input bit sel, input logic [3:0] mask, input logic [3:0] addr);
        if (sel) begin ib.ren = mask; ib.raddr = {4{addr}}; end
        else     begin ia.ren = mask; ia.raddr = {4{addr}}; end
        cyc();
        if (sel) ib.ren = '0; else ia.ren = '0;
        repeat ((sel ? 3 : 1) - 1) cyc();
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        nvec++; if (ia.dvalid !== 4'h0 || ib.dvalid !== 4'h0) begin nmis++; $display("FAIL reset_dvalid: a=%h b=%h expected 0", ia.dvalid, ib.dvalid); end
        nvec++; if (ia.dout !== '0 || ib.dout !== '0) begin nmis++; $display("FAIL reset_dout: a=%h b=%h expected 0", ia.dout, ib.dout); end
        nvec++; if (ia.busy !== 1'b0 || ib.busy !== 1'b0) begin nmis++; $display("FAIL reset_busy: a=%b b=%b expected 0", ia.busy, ib.busy); end
        cyc(); cyc();
        rst_a = 1'b1; rst_b = 1'b1;
        cyc();
    endtask

    task automatic test_write_read();
        wr(0, 4'b0100, 4'd5, 32'hDEADBEEF);
        ia.ren = 4'b0100; ia.raddr = {4{4'd5}};
        nvec++; if (ia.dvalid !== 4'b0000) begin nmis++; $display("FAIL wr_pre_dvalid: got %b expected 0000", ia.dvalid); end
        cyc();
        ia.ren = '0;
        nvec++; if (ia.dvalid !== 4'b0100) begin nmis++; $display("FAIL wr_dvalid: got %b expected 0100", ia.dvalid); end
        nvec++; if (ia.dout !== {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}) begin nmis++; $display("FAIL wr_dout: got %h expected %h", ia.dout, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}); end
        cyc();
        nvec++; if (ia.dvalid !== 4'b0000) begin nmis++; $display("FAIL wr_dvalid_drop: got %b expected 0000", ia.dvalid); end
        nvec++; if (ia.dout[64 +: 32] !== 32'hDEADBEEF) begin nmis++; $display("FAIL wr_dout_hold: got %h expected deadbeef", ia.dout[64 +: 32]); end
    endtask

    task automatic test_collision(input bit sel, input logic [31:0] exp_first);
        logic [31:0] got;
        wr(sel, 4'b0001, 4'd9, 32'h11);
        if (sel) begin ib.wen = 4'b0001; ib.ren = 4'b0001; ib.waddr = {4{4'd9}}; ib.raddr = {4{4'd9}}; ib.din = {4{32'h22}}; end
        else     begin ia.wen = 4'b0001; ia.ren = 4'b0001; ia.waddr = {4{4'd9}}; ia.raddr = {4{4'd9}}; ia.din = {4{32'h22}}; end
        cyc();
        if (sel) begin ib.wen = '0; ib.ren = '0; end else begin ia.wen = '0; ia.ren = '0; end
        repeat ((sel ? 3 : 1) - 1) cyc();
        got = sel ? ib.dout[31:0] : ia.dout[31:0];
        nvec++; if (got !== exp_first || (sel ? ib.dvalid[0] : ia.dvalid[0]) !== 1'b1) begin nmis++; $display("FAIL collision_%0d: got %h expected %h", sel, got, exp_first); end
        rd(sel, 4'b0001, 4'd9);
        got = sel ? ib.dout[31:0] : ia.dout[31:0];
        nvec++; if (got !== 32'h22) begin nmis++; $display("FAIL collision_after_%0d: got %h expected 22", sel, got); end
    endtask

    task automatic test_out_of_range();
        wr(0, 4'b0010, 4'd1, 32'hA1);
        wr(0, 4'b0010, 4'd13, 32'h55);
        rd(0, 4'b0010, 4'd13);
        nvec++; if (ia.dvalid !== 4'b0010 || ia.dout[32 +: 32] !== 32'h0) begin nmis++; $display("FAIL oor_read: dvalid %b data %h expected 0010 00000000", ia.dvalid, ia.dout[32 +: 32]); end
        rd(0, 4'b0010, 4'd1);
        nvec++; if (ia.dout[32 +: 32] !== 32'hA1) begin nmis++; $display("FAIL oor_alias: got %h expected a1", ia.dout[32 +: 32]); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_v;
        logic [31:0] exp_d;
        for (int a = 0; a < 8; a++) wr(1, 4'hF, 4'(a), 32'(a + 100));
        for (int k = 1; k <= 12; k++) begin
            if (k <= 8) begin ib.ren = 4'hF; ib.raddr = {4{4'(k - 1)}}; end
            else ib.ren = '0;
            cyc();
            exp_v = (k >= 3 && k <= 10) ? 4'hF : 4'h0;
            nvec++; if (ib.dvalid !== exp_v) begin nmis++; $display("FAIL b2b_dvalid_%0d: got %h expected %h", k, ib.dvalid, exp_v); end
            if (exp_v != 4'h0) begin
                exp_d = 32'(k + 97);
                nvec++; if (ib.dout !== {4{exp_d}}) begin nmis++; $display("FAIL b2b_data_%0d: got %h expected %h", k, ib.dout, {4{exp_d}}); end
            end
        end
    endtask

    task automatic test_clear();
        int n;
        for (int a = 0; a < 16; a++) wr(1, 4'hF, 4'(a), 32'(a + 'h200));
        ib.clr_start = 1'b1;
        cyc();
        ib.clr_start = 1'b0;
        n = 0;
        while (ib.busy === 1'b1 && n < 40) begin
            n++;
            ib.wen = 4'hF; ib.waddr = {4{4'd3}}; ib.din = {4{32'hBAD}};
            ib.ren = 4'hF; ib.raddr = {4{4'd3}};
            ib.clr_start = (n == 8);
            nvec++; if (ib.dvalid !== 4'h0) begin nmis++; $display("FAIL clr_dvalid_%0d: got %h expected 0", n, ib.dvalid); end
            cyc();
        end
        ib.wen = '0; ib.ren = '0; ib.clr_start = 1'b0;
        nvec++; if (n != 16) begin nmis++; $display("FAIL clr_busy_len: got %0d expected 16", n); end
        repeat (3) begin
            nvec++; if (ib.dvalid !== 4'h0 || ib.busy !== 1'b0) begin nmis++; $display("FAIL clr_tail: dvalid %h busy %b expected 0 0", ib.dvalid, ib.busy); end
            cyc();
        end
        for (int a = 0; a < 16; a++) begin
            rd(1, 4'hF, 4'(a));
            nvec++; if (ib.dvalid !== 4'hF || ib.dout !== '0) begin nmis++; $display("FAIL clr_zero_%0d: dvalid %h data %h expected f 0", a, ib.dvalid, ib.dout); end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] exp_d;
        for (int a = 0; a < 16; a++) wr(1, 4'hF, 4'(a), 32'(a + 'h300));
        ib.clr_start = 1'b1; ib.ren = 4'hF; ib.raddr = {4{4'd15}};
        cyc();
        ib.clr_start = 1'b0; ib.ren = '0;
        nvec++; if (ib.busy !== 1'b1) begin nmis++; $display("FAIL rmc_busy_rise: got %b expected 1", ib.busy); end
        cyc(); cyc();
        nvec++; if (ib.dvalid !== 4'hF || ib.dout !== {4{32'h30F}}) begin nmis++; $display("FAIL rmc_inflight: dvalid %h data %h expected f %h", ib.dvalid, ib.dout, {4{32'h30F}}); end
        cyc(); cyc(); cyc();
        rst_b = 1'b0;
        #1;
        nvec++; if (ib.busy !== 1'b0 || ib.dvalid !== 4'h0 || ib.dout !== '0) begin nmis++; $display("FAIL rmc_async: busy %b dvalid %h dout %h expected 0 0 0", ib.busy, ib.dvalid, ib.dout); end
        cyc();
        rst_b = 1'b1;
        cyc(); cyc();
        nvec++; if (ib.busy !== 1'b0) begin nmis++; $display("FAIL rmc_no_restart: got %b expected 0", ib.busy); end
        for (int a = 0; a < 16; a++) begin
            if (a == 5) continue;
            exp_d = (a < 5) ? 32'h0 : 32'(a + 'h300);
            rd(1, 4'hF, 4'(a));
            nvec++; if (ib.dout !== {4{exp_d}}) begin nmis++; $display("FAIL rmc_data_%0d: got %h expected %h", a, ib.dout, {4{exp_d}}); end
        end
    endtask

    initial begin
        ia.wen = '0; ia.waddr = '0; ia.din = '0; ia.ren = '0; ia.raddr = '0; ia.clr_start = 1'b0;
        ib.wen = '0; ib.waddr = '0; ib.din = '0; ib.ren = '0; ib.raddr = '0; ib.clr_start = 1'b0;
        test_reset();
        test_write_read();
        test_collision(0, 32'h11);
        test_collision(1, 32'h22);
        test_out_of_range();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
